core_instr_encoder: RTL
=======================

// Module: core_instr_encoder
// PURPOSE
// - Inverse of the decode-side immediate extraction: packs opcode, register fields and a 32-bit immediate into RV32I words.
// - Expands LI and CALL pseudo-ops into LUI/AUIPC + ADDI/JALR pairs.
// - Range-checks the immediate against the target format.
// - Valid/ready stream block. Feeds the boot-ROM patcher, self-test generator and debug-module program buffer.
// PARAMETERS
// - none: XLEN fixed at 32.
// PORTS
// clk        in   1   core clock
// rst_n      in   1   asynchronous active-low reset
// in_valid   in   1   request valid
// in_ready   out  1   request accepted when in_valid && in_ready
// in_kind    in   2   rv::enc_kind_t: ENC_RAW=0, ENC_LI=1, ENC_CALL=2 (3 is reserved and treated as RAW)
// in_opcode  in   5   rv::OPCODE_*, i.e. instr[6:2] (RAW only)
// in_funct3  in   3   funct3 (RAW only)
// in_funct7  in   7   funct7 (RAW, OP opcode only)
// in_rd      in   5   destination register
// in_rs1     in   5   source register 1 (RAW only)
// in_rs2     in   5   source register 2 (RAW only)
// in_imm     in   32  immediate (byte offset for B/J; full value for LI/CALL)
// out_valid  out  1   encoded word valid
// out_ready  in   1   sink accepts the word
// out_instr  out  32  encoded instruction; bits[1:0]=2'b11 always
// out_last   out  1   final word of this request
// out_err    out  1   immediate not representable; fields truncated, word still emitted
// BEHAVIOUR
// - Reset: out_valid=0, out_instr=0, out_last=0, out_err=0, state=IDLE, in_ready=1.
// - Latency: accept at edge N -> word registered and visible at N+1.
// - out_* held stable while out_valid && !out_ready (no combinational path in->out).
// - in_ready = (state==IDLE) && (!out_valid || out_ready). Single-word ops sustain 1 word/cycle.
// - FSM: IDLE, HOLD2.
//   - IDLE: on accept of a single-word op, load the word with last=1 and stay in IDLE.
//   - IDLE: on accept of a two-word op, load word 1 with last=0, latch word 2 into pending register, go to HOLD2.
//   - HOLD2: on out_ready, load pending word with last=1 and go to IDLE.
// - RAW format select on in_opcode:
//   - OPIMM/LOAD/JALR/SYSTEM -> I.
//   - STORE -> S. BRANCH -> B. LUI/AUIPC -> U. JAL -> J. OP -> R (imm ignored).
//   - Any other opcode -> out_err=1, and out_instr carries opcode bits only.
// - Range rules (err if violated):
//   - I/S: imm sign-extends from bit 11.
//   - B: imm in [-4096, 4094] and imm[0]=0.
//   - J: imm in [-2^20, 2^20-2] and imm[0]=0.
//   - U: imm[11:0]=0 (imm[31:12] goes to the field).
// - OPIMM shifts (funct3=001/101): funct7 is placed in bits[31:25]; imm[4:0] gives shamt; err if imm[11:5]!=0.
// - LI: lo = sext(imm[11:0]), hi = (imm + 32'h800) >> 12, computed mod 2^32 (wrap is legal).
//   - If imm fits 12-bit signed: one word, ADDI rd,x0,imm.
//   - Else if lo==0: one word, LUI rd,hi.
//   - Else two words: LUI rd,hi then ADDI rd,rd,lo. LI never errs.
// - CALL: always two words: AUIPC rd,hi then JALR rd,rd,lo (funct3=000). Never errs.
// - ENC_LI/CALL with rd=x0: encoded as given, no err.
// - rst_n low mid-HOLD2: pending word discarded; outputs return to reset values asynchronously.
// STRUCTURE
// - rv package additions:
//   - enc_kind_t.
//   - enc_fmt_t {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD}.
//   - FUNCT3_ADDI, FUNCT3_JALR.
//   - Function imm_fits_signed(value, bits).
// - Sub-module core_instr_pack (combinational): fmt + fields + imm -> {word, err}.
//   - Instantiated twice: first word and pending word.
// - Top holds FSM, output register and pending register.
// TESTING
// - RAW OPIMM addi x5,x0,-1 -> out_instr=32'hFFF00293, last=1, err=0, one cycle after accept.
// - LI x10,32'h12345678 -> 32'h12345537 (last=0), then 32'h67850513 (last=1); in_ready low between.
// - LI x10,32'h00000FFF -> 32'h00001537, then 32'hFFF50513; LI x10,32'h7FFFF800 -> LUI hi=20'h80000, ADDI lo=-2048.
// - BRANCH beq x1,x2,+8 -> 32'h00208463, err=0; same with imm=3 -> err=1; imm=4096 -> err=1.
// - Backpressure: out_ready=0 for 3 cycles during CALL word 1 -> word and last held stable, in_ready=0, then word 2 follows.
// - Async reset asserted in HOLD2 -> out_valid=0 immediately; next accept emits a fresh word, pending word never appears.

Source files
------------

// File: rtl/core_instr_encoder_pkg.sv
// Shared types, opcode constants and helpers for the RV32I instruction encoder.
package core_instr_encoder_pkg;

    typedef enum logic [1:0] {
        ENC_RAW  = 2'd0,
        ENC_LI   = 2'd1,
        ENC_CALL = 2'd2,
        ENC_RSVD = 2'd3
    } enc_kind_t;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } enc_fmt_t;

    // Major opcodes as instr[6:2]
    localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
    localparam logic [4:0] OPCODE_OPIMM  = 5'b00100;
    localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
    localparam logic [4:0] OPCODE_STORE  = 5'b01000;
    localparam logic [4:0] OPCODE_OP     = 5'b01100;
    localparam logic [4:0] OPCODE_LUI    = 5'b01101;
    localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
    localparam logic [4:0] OPCODE_JALR   = 5'b11001;
    localparam logic [4:0] OPCODE_JAL    = 5'b11011;
    localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;

    localparam logic [2:0] FUNCT3_ADDI = 3'b000;
    localparam logic [2:0] FUNCT3_JALR = 3'b000;

    // True when value is the sign extension of its low 'bits' bits.
    function automatic logic imm_fits_signed(input logic [31:0] value, input int unsigned bits);
        logic [31:0] upper_mask;
        logic [31:0] upper;
        upper_mask = 32'hFFFF_FFFF << (bits - 1);
        upper      = value & upper_mask;
        return (upper == 32'd0) || (upper == upper_mask);
    endfunction

    // Instruction format implied by a raw major opcode.
    function automatic enc_fmt_t raw_fmt(input logic [4:0] opcode);
        case (opcode)
            OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR, OPCODE_SYSTEM: return FMT_I;
            OPCODE_STORE:                                          return FMT_S;
            OPCODE_BRANCH:                                         return FMT_B;
            OPCODE_LUI, OPCODE_AUIPC:                              return FMT_U;
            OPCODE_JAL:                                            return FMT_J;
            OPCODE_OP:                                             return FMT_R;
            default:                                               return FMT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/core_instr_encoder_pack.sv
// Combinational packer: format + fields + immediate -> 32-bit RV32I word and range error.
module core_instr_pack
    import core_instr_encoder_pkg::*;
(
    input  enc_fmt_t     fmt,
    input  logic [4:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    input  logic [4:0]   rd,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    input  logic [31:0]  imm,
    output logic [31:0]  word,
    output logic         err
);

    logic is_shift;

    assign is_shift = (opcode == OPCODE_OPIMM) && (funct3[1:0] == 2'b01);

    // Scatter immediate bits into the selected format and flag unrepresentable values
    always_comb begin
        word = {25'd0, opcode, 2'b11};
        err  = 1'b0;
        case (fmt)
            FMT_R: begin
                word = {funct7, rs2, rs1, funct3, rd, opcode, 2'b11};
            end
            FMT_I: begin
                if (is_shift) begin
                    word = {funct7, imm[4:0], rs1, funct3, rd, opcode, 2'b11};
                    err  = (imm[11:5] != 7'd0);
                end else begin
                    word = {imm[11:0], rs1, funct3, rd, opcode, 2'b11};
                    err  = !imm_fits_signed(imm, 12);
                end
            end
            FMT_S: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode, 2'b11};
                err  = !imm_fits_signed(imm, 12);
            end
            FMT_B: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode, 2'b11};
                err  = !imm_fits_signed(imm, 13) || imm[0];
            end
            FMT_U: begin
                word = {imm[31:12], rd, opcode, 2'b11};
                err  = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode, 2'b11};
                err  = !imm_fits_signed(imm, 21) || imm[0];
            end
            default: begin
                word = {25'd0, opcode, 2'b11};
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/core_instr_encoder.sv
// RV32I instruction encoder: raw fields or LI/CALL pseudo-ops in, one or two words out.
module core_instr_encoder
    import core_instr_encoder_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_kind,
    input  logic [4:0]   in_opcode,
    input  logic [2:0]   in_funct3,
    input  logic [6:0]   in_funct7,
    input  logic [4:0]   in_rd,
    input  logic [4:0]   in_rs1,
    input  logic [4:0]   in_rs2,
    input  logic [31:0]  in_imm,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_instr,
    output logic         out_last,
    output logic         out_err
);

    typedef enum logic {IDLE, HOLD2} state_t;

    state_t       state, state_nxt;
    enc_kind_t    kind_p0;
    logic         accept;

    logic [31:0]  lo_p0;
    logic [31:0]  hi_word_p0;
    logic         two_p0;
    logic         err_mask_p0;

    enc_fmt_t     a_fmt_p0;
    logic [4:0]   a_opcode_p0;
    logic [2:0]   a_funct3_p0;
    logic [6:0]   a_funct7_p0;
    logic [4:0]   a_rs1_p0;
    logic [4:0]   a_rs2_p0;
    logic [31:0]  a_imm_p0;
    logic [31:0]  a_word_p0;
    logic         a_err_p0;

    enc_fmt_t     b_fmt_p0;
    logic [4:0]   b_opcode_p0;
    logic [2:0]   b_funct3_p0;
    logic [31:0]  b_word_p0;
    logic         b_err_p0;

    logic [31:0]  pend_p1;

    assign kind_p0    = enc_kind_t'(in_kind);
    assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign lo_p0      = {{20{in_imm[11]}}, in_imm[11:0]};
    // Rounded upper part: adding 0x800 compensates for the sign of lo; wrap is intended
    assign hi_word_p0 = (in_imm + 32'h0000_0800) & 32'hFFFF_F000;

    // Select first/second word fields from the request kind
    always_comb begin
        a_fmt_p0    = raw_fmt(in_opcode);
        a_opcode_p0 = in_opcode;
        a_funct3_p0 = in_funct3;
        a_funct7_p0 = in_funct7;
        a_rs1_p0    = in_rs1;
        a_rs2_p0    = in_rs2;
        a_imm_p0    = in_imm;
        b_fmt_p0    = FMT_I;
        b_opcode_p0 = OPCODE_OPIMM;
        b_funct3_p0 = FUNCT3_ADDI;
        two_p0      = 1'b0;
        err_mask_p0 = 1'b0;
        case (kind_p0)
            ENC_LI: begin
                err_mask_p0 = 1'b1;
                a_funct7_p0 = 7'd0;
                a_rs2_p0    = 5'd0;
                if (imm_fits_signed(in_imm, 12)) begin
                    a_fmt_p0    = FMT_I;
                    a_opcode_p0 = OPCODE_OPIMM;
                    a_funct3_p0 = FUNCT3_ADDI;
                    a_rs1_p0    = 5'd0;
                    a_imm_p0    = in_imm;
                end else begin
                    a_fmt_p0    = FMT_U;
                    a_opcode_p0 = OPCODE_LUI;
                    a_funct3_p0 = 3'd0;
                    a_rs1_p0    = 5'd0;
                    a_imm_p0    = hi_word_p0;
                    two_p0      = (in_imm[11:0] != 12'd0);
                end
            end
            ENC_CALL: begin
                err_mask_p0 = 1'b1;
                a_fmt_p0    = FMT_U;
                a_opcode_p0 = OPCODE_AUIPC;
                a_funct3_p0 = 3'd0;
                a_funct7_p0 = 7'd0;
                a_rs1_p0    = 5'd0;
                a_rs2_p0    = 5'd0;
                a_imm_p0    = hi_word_p0;
                b_opcode_p0 = OPCODE_JALR;
                b_funct3_p0 = FUNCT3_JALR;
                two_p0      = 1'b1;
            end
            default: begin
                two_p0 = 1'b0;
            end
        endcase
    end

    core_instr_pack u_pack_first (
        .fmt    (a_fmt_p0),
        .opcode (a_opcode_p0),
        .funct3 (a_funct3_p0),
        .funct7 (a_funct7_p0),
        .rd     (in_rd),
        .rs1    (a_rs1_p0),
        .rs2    (a_rs2_p0),
        .imm    (a_imm_p0),
        .word   (a_word_p0),
        .err    (a_err_p0)
    );

    core_instr_pack u_pack_second (
        .fmt    (b_fmt_p0),
        .opcode (b_opcode_p0),
        .funct3 (b_funct3_p0),
        .funct7 (7'd0),
        .rd     (in_rd),
        .rs1    (in_rd),
        .rs2    (5'd0),
        .imm    (lo_p0),
        .word   (b_word_p0),
        .err    (b_err_p0)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: enter HOLD2 on a two-word accept, leave once word 1 is taken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && two_p0) state_nxt = HOLD2;
            HOLD2:   if (out_ready)        state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p0 -> p1: output word and pending second word ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            pend_p1   <= 32'd0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= a_word_p0;
            out_last  <= !two_p0;
            out_err   <= a_err_p0 && !err_mask_p0;
            if (two_p0) pend_p1 <= b_word_p0;
        end else if (state == HOLD2 && out_ready) begin
            out_valid <= 1'b1;
            out_instr <= pend_p1;
            out_last  <= 1'b1;
            out_err   <= b_err_p0 && 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
